// File: rtl/burst_acc_pkg.sv
// Shared definitions for the burst accumulator.
//   state_t          : controller states (IDLE / ACCUM / HOLD)
//   ACC_WIDTH_OFFSET : default guard bits added on top of the input width
package burst_acc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam int ACC_WIDTH_OFFSET = 4;

endpackage : burst_acc_pkg

// File: rtl/burst_accumulator.sv
// Burst accumulator: sums a programmable number of unsigned adder results
// into a wider accumulator and presents each finished burst sum on a
// valid/ready output together with a sticky overflow flag and the beat count.
//
// Ports:
//   clock      in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   flush      in   synchronous abort of a partial burst (ignored in HOLD)
//   cfg_len    in   burst length minus one, sampled on the first beat
//   in_valid   in   in_data valid
//   in_ready   out  beat accepted this cycle when in_valid is also high
//   in_data    in   unsigned adder result
//   out_valid  out  out_sum/out_ovf/out_beats hold a completed burst
//   out_ready  in   consumer accepts the result
//   out_sum    out  burst sum modulo 2^ACC_WIDTH
//   out_ovf    out  burst sum wrapped at least once
//   out_beats  out  number of beats in the burst (cfg_len + 1)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for the first beat of a burst
// S_ACCUM | burst in progress, adding beats until the latched length
// S_HOLD  | result registered on the output, waiting for out_ready
module burst_accumulator
  import burst_acc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = WIDTH + ACC_WIDTH_OFFSET,
  parameter int LEN_BITS  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [LEN_BITS-1:0]   cfg_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic                  out_ovf,
  output logic [LEN_BITS:0]     out_beats
);

  state_t                state, state_n;
  logic [ACC_WIDTH-1:0]  acc, acc_n;
  logic [LEN_BITS-1:0]   count, count_n;
  logic [LEN_BITS-1:0]   len, len_n;
  logic                  ovf, ovf_n;
  logic [ACC_WIDTH-1:0]  out_sum_n;
  logic                  out_ovf_n;
  logic [LEN_BITS:0]     out_beats_n;

  logic [ACC_WIDTH-1:0]  data_acc;
  logic [ACC_WIDTH:0]    sum_wide;
  logic [LEN_BITS-1:0]   count_inc;
  logic                  take_first;

  // In HOLD the input is only opened while the result drains, so the first
  // beat of the next burst can overlap the output handshake.
  assign in_ready  = (state == S_HOLD) ? out_ready : 1'b1;
  assign out_valid = (state == S_HOLD);

  assign data_acc  = ACC_WIDTH'(in_data);
  assign sum_wide  = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(in_data);
  assign count_inc = count + LEN_BITS'(1);

  // First beat: from IDLE unless flushed, or from HOLD during the drain
  // (flush has no effect in HOLD).
  assign take_first = in_valid &&
                      (((state == S_IDLE) && !flush) ||
                       ((state == S_HOLD) && out_ready));

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    count_n     = count;
    len_n       = len;
    ovf_n       = ovf;
    out_sum_n   = out_sum;
    out_ovf_n   = out_ovf;
    out_beats_n = out_beats;

    if (take_first) begin
      len_n   = cfg_len;
      acc_n   = data_acc;
      count_n = '0;
      ovf_n   = 1'b0;
      if (cfg_len == '0) begin
        state_n     = S_HOLD;
        out_sum_n   = data_acc;
        out_ovf_n   = 1'b0;
        out_beats_n = (LEN_BITS+1)'(1);
      end else begin
        state_n = S_ACCUM;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (flush) begin
            acc_n   = '0;
            count_n = '0;
            ovf_n   = 1'b0;
          end
        end
        S_ACCUM: begin
          if (flush) begin
            state_n = S_IDLE;
            acc_n   = '0;
            count_n = '0;
            ovf_n   = 1'b0;
          end else if (in_valid) begin
            acc_n   = sum_wide[ACC_WIDTH-1:0];
            ovf_n   = ovf | sum_wide[ACC_WIDTH];
            count_n = count_inc;
            if (count_inc == len) begin
              state_n     = S_HOLD;
              out_sum_n   = sum_wide[ACC_WIDTH-1:0];
              out_ovf_n   = ovf | sum_wide[ACC_WIDTH];
              out_beats_n = (LEN_BITS+1)'(len) + (LEN_BITS+1)'(1);
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_n = S_IDLE;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      count     <= '0;
      len       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_beats <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      count     <= count_n;
      len       <= len_n;
      ovf       <= ovf_n;
      out_sum   <= out_sum_n;
      out_ovf   <= out_ovf_n;
      out_beats <= out_beats_n;
    end
  end

endmodule : burst_accumulator

// File: tb/tb_burst_accumulator.sv
// Directed bench for burst_accumulator (WIDTH=8, ACC_WIDTH=10, LEN_BITS=4).
module tb_burst_accumulator;

  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 10;
  localparam int LEN_BITS  = 4;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 flush;
  logic [LEN_BITS-1:0]  cfg_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_ovf;
  logic [LEN_BITS:0]    out_beats;

  int n_checks = 0;
  int n_fail   = 0;

  burst_accumulator #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .LEN_BITS (LEN_BITS)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .cfg_len  (cfg_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .out_beats(out_beats)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [LEN_BITS-1:0] l);
    in_valid = 1'b1;
    in_data  = d;
    cfg_len  = l;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    cfg_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_sum",   16'(out_sum),   16'd0);
    check("rst_out_ovf",   16'(out_ovf),   16'd0);
    check("rst_out_beats", 16'(out_beats), 16'd0);
    reset_n = 1'b1;
    step();
    check("rst_in_ready",  16'(in_ready),  16'd1);

    // Basic burst: 10+20+30+40
    send(8'd10, 4'd3);
    check("basic_mid_valid", 16'(out_valid), 16'd0);
    send(8'd20, 4'd3);
    send(8'd30, 4'd3);
    send(8'd40, 4'd3);
    check("basic_valid", 16'(out_valid), 16'd1);
    check("basic_sum",   16'(out_sum),   16'd100);
    check("basic_ovf",   16'(out_ovf),   16'd0);
    check("basic_beats", 16'(out_beats), 16'd4);
    step();
    check("basic_drained", 16'(out_valid), 16'd0);

    // Overflow: five beats of 255 = 1275 -> 251 with wrap
    for (int i = 0; i < 5; i++) send(8'd255, 4'd4);
    check("ovf_valid", 16'(out_valid), 16'd1);
    check("ovf_sum",   16'(out_sum),   16'd251);
    check("ovf_flag",  16'(out_ovf),   16'd1);
    check("ovf_beats", 16'(out_beats), 16'd5);
    step();
    check("ovf_drained", 16'(out_valid), 16'd0);

    // Backpressure with single-beat bursts
    out_ready = 1'b0;
    send(8'd7, 4'd0);
    check("bp_valid", 16'(out_valid), 16'd1);
    check("bp_sum",   16'(out_sum),   16'd7);
    check("bp_beats", 16'(out_beats), 16'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_in_ready", 16'(in_ready),  16'd0);
      check("bp_hold_valid",    16'(out_valid), 16'd1);
      check("bp_hold_sum",      16'(out_sum),   16'd7);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd9;
    cfg_len   = 4'd0;
    #1;
    check("b2b_in_ready", 16'(in_ready), 16'd1);
    step();
    in_valid = 1'b0;
    check("b2b_valid", 16'(out_valid), 16'd1);
    check("b2b_sum",   16'(out_sum),   16'd9);
    step();
    check("b2b_drained", 16'(out_valid), 16'd0);

    // Drain with a multi-beat next burst: 3+4 started during the handshake
    out_ready = 1'b0;
    send(8'd100, 4'd0);
    out_ready = 1'b1;
    send(8'd3, 4'd1);
    check("overlap_first_valid", 16'(out_valid), 16'd0);
    send(8'd4, 4'd1);
    check("overlap_sum",   16'(out_sum),   16'd7);
    check("overlap_beats", 16'(out_beats), 16'd2);
    step();

    // Flush mid-burst drops the partial sum and the same-cycle beat
    send(8'd1, 4'd3);
    send(8'd2, 4'd3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd50;
    #1;
    check("flush_in_ready", 16'(in_ready), 16'd1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 16'(out_valid), 16'd0);
    step();
    send(8'd5, 4'd1);
    send(8'd6, 4'd1);
    check("after_flush_valid", 16'(out_valid), 16'd1);
    check("after_flush_sum",   16'(out_sum),   16'd11);
    check("after_flush_beats", 16'(out_beats), 16'd2);
    step();

    // Flush in HOLD is ignored
    out_ready = 1'b0;
    send(8'd10, 4'd3);
    send(8'd20, 4'd3);
    send(8'd30, 4'd3);
    send(8'd40, 4'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("hold_flush_valid", 16'(out_valid), 16'd1);
    check("hold_flush_sum",   16'(out_sum),   16'd100);
    step();
    out_ready = 1'b1;
    check("hold_flush_deliver", 16'(out_sum), 16'd100);
    step();
    check("hold_flush_drained", 16'(out_valid), 16'd0);

    // Longest burst: 16 beats of 1
    for (int i = 0; i < 16; i++) send(8'd1, 4'd15);
    check("max_valid", 16'(out_valid), 16'd1);
    check("max_sum",   16'(out_sum),   16'd16);
    check("max_beats", 16'(out_beats), 16'd16);
    step();

    // Async reset mid-ACCUM
    send(8'd1, 4'd3);
    send(8'd2, 4'd3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_accum_valid", 16'(out_valid), 16'd0);
    check("arst_accum_sum",   16'(out_sum),   16'd0);
    reset_n = 1'b1;
    step();

    // Async reset mid-HOLD
    out_ready = 1'b0;
    send(8'd200, 4'd0);
    check("pre_arst_hold_valid", 16'(out_valid), 16'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_hold_valid", 16'(out_valid), 16'd0);
    check("arst_hold_sum",   16'(out_sum),   16'd0);
    check("arst_hold_beats", 16'(out_beats), 16'd0);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    send(8'd3, 4'd1);
    send(8'd4, 4'd1);
    check("post_arst_valid", 16'(out_valid), 16'd1);
    check("post_arst_sum",   16'(out_sum),   16'd7);
    check("post_arst_ovf",   16'(out_ovf),   16'd0);
    step();
    check("post_arst_drained", 16'(out_valid), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_burst_accumulator

// File: doc/burst_accumulator.md
Name: burst_accumulator

Overview:
- Downstream consumer of the adder result stream. Sums a configurable-length burst of WIDTH-bit results into a wider accumulator.
- Presents each finished burst sum on a valid/ready output with an overflow flag.
- Used in energy-characterization runs to reduce long operand sweeps to one word per burst.

Parameters:
- WIDTH, 32, bit width of each incoming adder result (matches the adder's WIDTH).
- ACC_WIDTH, WIDTH+4, accumulator and output sum width; must be >= WIDTH.
- LEN_BITS, 8, width of the burst-length field; max burst is 2^LEN_BITS beats.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the partial burst.
- cfg_len  input  LEN_BITS  beats minus 1; sampled only on the first beat of a burst.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  adder result, unsigned.
- out_valid  output  1  out_sum/out_ovf/out_beats hold a completed burst.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_WIDTH  burst sum modulo 2^ACC_WIDTH.
- out_ovf  output  1  burst sum exceeded 2^ACC_WIDTH-1 at least once.
- out_beats  output  LEN_BITS+1  beats in the burst (cfg_len+1).

Behaviour:
- Reset (reset_n=0, async): state IDLE; accumulator, beat counter and latched length = 0; out_valid=0, out_sum=0, out_ovf=0, out_beats=0. in_ready is 1 once reset is released.
- Input handshake: a beat is accepted when in_valid && in_ready. Output handshake: a transfer completes when out_valid && out_ready.
- States: IDLE, ACCUM, HOLD.
- in_ready by state:
  - 1 in IDLE and ACCUM.
  - Equal to out_ready in HOLD, so the first beat of the next burst can be taken in the cycle the result drains.
- First beat (accepted in IDLE, or in HOLD while draining):
  - Latch cfg_len, load acc = zero-extended in_data, count = 0, clear ovf.
  - If cfg_len == 0, go to HOLD; otherwise go to ACCUM.
- ACCUM beat:
  - acc = acc + in_data, computed ACC_WIDTH+1 wide. A carry out sets the sticky ovf and the acc wraps.
  - count++. When count reaches the latched length, go to HOLD.
- Latency: last beat accepted at edge t gives out_valid=1 with final values after edge t (visible in cycle t+1).
- HOLD:
  - out_valid=1. out_sum, out_ovf and out_beats are registered and stable until the handshake.
  - On handshake without a new input beat: go to IDLE, out_valid=0.
  - On handshake with a new input beat: load the new burst per the first-beat rule. out_valid stays 1 only if the new cfg_len == 0, with the new values.
- Arithmetic: unsigned only, no saturation. out_beats = latched length + 1; a length of 2^LEN_BITS-1 gives 2^LEN_BITS.
- flush:
  - In ACCUM or IDLE: next state IDLE, acc/count/ovf cleared, any same-cycle input beat discarded. in_ready remains 1, but the beat is dropped.
  - In HOLD: ignored; the completed result is never dropped.
- No input while in ACCUM: state holds indefinitely; no timeout.
- Async reset mid-burst or while in HOLD discards everything immediately. out_valid drops without a handshake.

Decomposition:
- Shared package burst_acc_pkg holds the state enum (IDLE/ACCUM/HOLD) and the default ACC_WIDTH offset constant (4).
- No sub-module is natural: the counter and adder are a few lines each. Implement as a single module.

Test Plan (WIDTH=8, ACC_WIDTH=10, LEN_BITS=4 unless noted):
- Basic burst: cfg_len=3, beats 10,20,30,40, out_ready=1 → one cycle after the 4th beat, out_valid=1, out_sum=100, out_ovf=0, out_beats=4; out_valid=0 the next cycle.
- Overflow: cfg_len=4, five beats of 255 (sum 1275) → out_sum=1275-1024=251, out_ovf=1, out_beats=5.
- Backpressure and back-to-back:
  - cfg_len=0 with out_ready=0: beat 7 gives out_valid=1, out_sum=7, and in_ready=0 while held for 5 cycles with the output stable.
  - Then raise out_ready together with in_valid, beat 9, cfg_len=0: out_valid stays 1 and out_sum=9 the next cycle.
- Flush mid-burst: cfg_len=3, beats 1,2, then flush=1 with in_valid=1/data 50 → beat 50 dropped, state IDLE. A new burst cfg_len=1 with beats 5,6 gives out_sum=11.
- Flush in HOLD: result 100 pending with out_ready=0, pulse flush → out_valid stays 1, out_sum=100 is delivered when out_ready=1.
- Async reset: drop reset_n mid-ACCUM and mid-HOLD → out_valid=0, out_sum=0 immediately, not at the next edge. After release, a cfg_len=1 burst of 3,4 gives 7.
